// File: rtl/riscv_pkg.sv
// Shared RV32 execute-stage definitions: M-extension funct3 codes, forwarding
// select codes and the multiply/divide FSM state and debug types.
package riscv_pkg;

   localparam logic [2:0] F3_MUL    = 3'b000;
   localparam logic [2:0] F3_MULH   = 3'b001;
   localparam logic [2:0] F3_MULHSU = 3'b010;
   localparam logic [2:0] F3_MULHU  = 3'b011;
   localparam logic [2:0] F3_DIV    = 3'b100;
   localparam logic [2:0] F3_DIVU   = 3'b101;
   localparam logic [2:0] F3_REM    = 3'b110;
   localparam logic [2:0] F3_REMU   = 3'b111;

   localparam logic [1:0] FWD_REG = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} md_state_t;

   typedef struct packed {
      md_state_t state;
      logic      div_busy;
   } md_dbg_t;

   // {rs1 signed, rs2 signed} for an M-op; MUL low bits do not depend on it.
   function automatic logic [1:0] op_signs(input logic [2:0] f3);
      logic [1:0] s;
      case (f3)
         F3_MUL, F3_MULH, F3_DIV, F3_REM: s = 2'b11;
         F3_MULHSU:                       s = 2'b10;
         default:                         s = 2'b00;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/div_iter.sv
// Restoring divider on unsigned magnitudes, one quotient bit per cycle.
// Final quotient/remainder are presented combinationally in the done cycle.
module div_iter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start_i,
   input  logic         clear_i,
   input  logic [W-1:0] dividend_i,
   input  logic [W-1:0] divisor_i,
   output logic         busy_o,
   output logic         done_o,
   output logic [W-1:0] quo_o,
   output logic [W-1:0] rem_o
);

   localparam int CW = $clog2(W);

   logic [W-1:0]  quo_q, quo_d, rem_q, rem_d, dsr_q;
   logic [CW-1:0] cnt_q;
   logic          busy_q;
   logic [W:0]    shifted, diff;

   always_comb begin
      shifted = {rem_q, quo_q[W-1]};
      diff    = shifted - {1'b0, dsr_q};
      // A borrow out of the top bit means the divisor did not fit: restore.
      if (diff[W]) begin
         rem_d = shifted[W-1:0];
         quo_d = {quo_q[W-2:0], 1'b0};
      end else begin
         rem_d = diff[W-1:0];
         quo_d = {quo_q[W-2:0], 1'b1};
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n || clear_i) begin
         quo_q  <= '0;
         rem_q  <= '0;
         dsr_q  <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b0;
      end else if (start_i) begin
         quo_q  <= dividend_i;
         rem_q  <= '0;
         dsr_q  <= divisor_i;
         cnt_q  <= CW'(W - 1);
         busy_q <= 1'b1;
      end else if (busy_q) begin
         quo_q <= quo_d;
         rem_q <= rem_d;
         cnt_q <= cnt_q - CW'(1);
         if (cnt_q == '0) busy_q <= 1'b0;
      end
   end

   assign busy_o = busy_q;
   assign done_o = busy_q && (cnt_q == '0);
   assign quo_o  = quo_d;
   assign rem_o  = rem_d;

endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage RV32M unit: forwarded operands, 2-cycle multiply, iterative divide,
// pipeline stall until the registered result is presented for one cycle.
module ex_muldiv_unit
   import riscv_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            valid_ex,
   input  logic            is_m_ex,
   input  logic [2:0]      funct3_ex,
   input  logic [XLEN-1:0] rs1_data_ex,
   input  logic [XLEN-1:0] rs2_data_ex,
   input  logic [XLEN-1:0] alu_result_mem,
   input  logic [XLEN-1:0] wb_data,
   input  logic [1:0]      forward_a,
   input  logic [1:0]      forward_b,
   input  logic            flush,
   output logic            stall,
   output logic            result_valid,
   output logic [XLEN-1:0] result,
   output md_dbg_t         dbg_o
);

   localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

   md_state_t         state_q, state_d;
   logic [XLEN-1:0]   op_a, op_b, op_a_q, op_b_q, mag_a, mag_b;
   logic [XLEN-1:0]   result_q, result_d;
   logic [2:0]        f3_q;
   logic [1:0]        sgn, sgn_q;
   logic              accept, special, spec_q, sdiv;
   logic [XLEN:0]     a_ext, b_ext;
   logic signed [2*XLEN-1:0] prod;
   logic              div_busy, div_done;
   logic [XLEN-1:0]   div_quo, div_rem, q_fix, r_fix, q_spec, r_spec;

   always_comb begin
      case (forward_a)
         FWD_WB:  op_a = wb_data;
         FWD_MEM: op_a = alu_result_mem;
         default: op_a = rs1_data_ex;
      endcase
      case (forward_b)
         FWD_WB:  op_b = wb_data;
         FWD_MEM: op_b = alu_result_mem;
         default: op_b = rs2_data_ex;
      endcase
   end

   assign accept  = (state_q == IDLE) && valid_ex && is_m_ex && !flush;
   assign sgn     = op_signs(funct3_ex);
   assign mag_a   = (sgn[1] && op_a[XLEN-1]) ? -op_a : op_a;
   assign mag_b   = (sgn[0] && op_b[XLEN-1]) ? -op_b : op_b;
   // Zero divisor and INT_MIN / -1 bypass the iteration entirely.
   assign special = funct3_ex[2] &&
                    ((op_b == '0) || (!funct3_ex[0] && op_a == INT_MIN && op_b == '1));

   div_iter #(.W(XLEN)) u_div (
      .clk        (clk),
      .rst_n      (rst_n),
      .start_i    (accept && funct3_ex[2] && !special),
      .clear_i    (flush),
      .dividend_i (mag_a),
      .divisor_i  (mag_b),
      .busy_o     (div_busy),
      .done_o     (div_done),
      .quo_o      (div_quo),
      .rem_o      (div_rem)
   );

   assign a_ext = {sgn_q[1] & op_a_q[XLEN-1], op_a_q};
   assign b_ext = {sgn_q[0] & op_b_q[XLEN-1], op_b_q};
   assign prod  = $signed(a_ext) * $signed(b_ext);

   assign sdiv   = !f3_q[0];
   assign q_fix  = (sdiv && (op_a_q[XLEN-1] ^ op_b_q[XLEN-1])) ? -div_quo : div_quo;
   assign r_fix  = (sdiv && op_a_q[XLEN-1]) ? -div_rem : div_rem;
   assign q_spec = (op_b_q == '0) ? '1 : INT_MIN;
   assign r_spec = (op_b_q == '0) ? op_a_q : '0;

   always_comb begin
      state_d  = state_q;
      result_d = result_q;
      case (state_q)
         IDLE: if (accept) state_d = funct3_ex[2] ? DIV : MUL;
         MUL: begin
            state_d  = DONE;
            result_d = (f3_q == F3_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
         end
         DIV: begin
            if (spec_q) begin
               state_d  = DONE;
               result_d = f3_q[1] ? r_spec : q_spec;
            end else if (div_done) begin
               state_d  = DONE;
               result_d = f3_q[1] ? r_fix : q_fix;
            end
         end
         default: state_d = IDLE;
      endcase
      if (flush) begin
         state_d  = IDLE;
         result_d = result_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         result_q <= '0;
         op_a_q   <= '0;
         op_b_q   <= '0;
         f3_q     <= '0;
         sgn_q    <= '0;
         spec_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         result_q <= result_d;
         if (accept) begin
            op_a_q <= op_a;
            op_b_q <= op_b;
            f3_q   <= funct3_ex;
            sgn_q  <= sgn;
            spec_q <= special;
         end
      end
   end

   assign stall        = rst_n && (accept || state_q == MUL || state_q == DIV);
   assign result_valid = rst_n && (state_q == DONE) && !flush;
   assign result       = result_q;
   assign dbg_o        = '{state: state_q, div_busy: div_busy};

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: directed M-op cases plus random ops
// against an arithmetic reference model, compared on every cycle.
module tb_ex_muldiv_unit;
   import riscv_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        valid_ex, is_m_ex, flush;
   logic [2:0]  funct3_ex;
   logic [31:0] rs1_data_ex, rs2_data_ex, alu_result_mem, wb_data;
   logic [1:0]  forward_a, forward_b;
   logic        stall, result_valid;
   logic [31:0] result;
   md_dbg_t     dbg;

   logic        chk_en = 1'b0;
   logic        exp_stall, exp_rv;
   logic [31:0] exp_result, last_result;
   int          n_checks = 0;
   int          n_errors = 0;

   always #5 clk = ~clk;

   ex_muldiv_unit #(.XLEN(32)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .valid_ex       (valid_ex),
      .is_m_ex        (is_m_ex),
      .funct3_ex      (funct3_ex),
      .rs1_data_ex    (rs1_data_ex),
      .rs2_data_ex    (rs2_data_ex),
      .alu_result_mem (alu_result_mem),
      .wb_data        (wb_data),
      .forward_a      (forward_a),
      .forward_b      (forward_b),
      .flush          (flush),
      .stall          (stall),
      .result_valid   (result_valid),
      .result         (result),
      .dbg_o          (dbg)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
      n_checks++;
      if (act !== want) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
      end
   endtask

   // Reference arithmetic straight from the RV32M definitions.
   function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      longint          p;
      longint unsigned pu;
      int              sa, sb;
      sa = a;
      sb = b;
      case (f3)
         F3_MUL:    begin p = longint'(sa) * longint'(sb); return p[31:0]; end
         F3_MULH:   begin p = longint'(sa) * longint'(sb); return p[63:32]; end
         F3_MULHSU: begin p = longint'(sa) * longint'({32'b0, b}); return p[63:32]; end
         F3_MULHU:  begin pu = {32'b0, a} * {32'b0, b}; return pu[63:32]; end
         F3_DIV:    begin
            if (b == 0) return 32'hFFFFFFFF;
            if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
            return sa / sb;
         end
         F3_DIVU:   return (b == 0) ? 32'hFFFFFFFF : a / b;
         F3_REM:    begin
            if (b == 0) return a;
            if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
            return sa % sb;
         end
         default:   return (b == 0) ? a : a % b;
      endcase
   endfunction

   function automatic int latency(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      if (!f3[2]) return 2;
      if (b == 0) return 2;
      if (!f3[0] && a == 32'h80000000 && b == 32'hFFFFFFFF) return 2;
      return 33;
   endfunction

   always @(negedge clk) begin
      if (chk_en) begin
         check("stall", {31'b0, stall}, {31'b0, exp_stall});
         check("result_valid", {31'b0, result_valid}, {31'b0, exp_rv});
         check("result", result, exp_result);
      end
   end

   task automatic scramble();
      rs1_data_ex    = $urandom;
      rs2_data_ex    = $urandom;
      alu_result_mem = $urandom;
      wb_data        = $urandom;
   endtask

   // abort_kind: 0 none, 1 flush, 2 reset, applied in cycle abort_cyc.
   task automatic drive_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                           input logic [1:0] fa, input logic [1:0] fb, input logic [31:0] want,
                           input int abort_cyc, input int abort_kind);
      int lat;
      lat = latency(f3, a, b);
      for (int k = 0; k <= lat; k++) begin
         @(posedge clk);
         #1;
         scramble();
         if (k == 0) begin
            valid_ex  = 1'b1;
            is_m_ex   = 1'b1;
            funct3_ex = f3;
            forward_a = fa;
            forward_b = fb;
            case (fa)
               2'b01:   wb_data = a;
               2'b10:   alu_result_mem = a;
               default: rs1_data_ex = a;
            endcase
            case (fb)
               2'b01:   wb_data = b;
               2'b10:   alu_result_mem = b;
               default: rs2_data_ex = b;
            endcase
         end else begin
            funct3_ex = 3'($urandom_range(0, 7));
         end
         if (abort_kind != 0 && k == abort_cyc) begin
            if (abort_kind == 1) flush = 1'b1;
            else rst_n = 1'b0;
            exp_stall  = (abort_kind == 1) && (k > 0);
            exp_rv     = 1'b0;
            exp_result = last_result;
            @(posedge clk);
            #1;
            flush    = 1'b0;
            rst_n    = 1'b1;
            valid_ex = 1'b0;
            if (abort_kind == 2) last_result = 32'h0;
            exp_stall  = 1'b0;
            exp_rv     = 1'b0;
            exp_result = last_result;
            return;
         end
         exp_stall  = (k < lat);
         exp_rv     = (k == lat);
         exp_result = (k == lat) ? want : last_result;
      end
      last_result = want;
      @(posedge clk);
      #1;
      valid_ex   = 1'($urandom_range(0, 1));
      is_m_ex    = 1'b0;
      exp_stall  = 1'b0;
      exp_rv     = 1'b0;
      exp_result = last_result;
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0:       return 32'h0;
         1:       return 32'hFFFFFFFF;
         2:       return 32'h80000000;
         3:       return 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      logic [2:0]  f3;
      logic [31:0] a, b;
      logic [1:0]  fa, fb;
      int          ab_cyc, ab_kind;

      rst_n = 1'b0; flush = 1'b0; funct3_ex = 3'b0;
      valid_ex = 1'b1; is_m_ex = 1'b1;
      forward_a = 2'b00; forward_b = 2'b00;
      scramble();
      exp_stall = 1'b0; exp_rv = 1'b0; exp_result = 32'h0; last_result = 32'h0;
      @(posedge clk);
      #1;
      chk_en = 1'b1;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      valid_ex = 1'b0;

      check("pin_mulhsu", model(F3_MULHSU, 32'hFFFFFFFF, 32'h2), 32'hFFFFFFFF);
      check("pin_rem", model(F3_REM, 32'hFFFFFFF9, 32'h2), 32'hFFFFFFFF);
      check("pin_divu", model(F3_DIVU, 32'hFFFFFFFF, 32'h2), 32'h7FFFFFFF);

      drive_op(F3_MUL,   32'd7,        32'hFFFFFFFD, 2'b00, 2'b10, 32'hFFFFFFEB, 0, 0);
      drive_op(F3_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 2'b00, 2'b00, 32'hFFFFFFFE, 0, 0);
      drive_op(F3_MULH,  32'h80000000, 32'h80000000, 2'b00, 2'b00, 32'h40000000, 0, 0);
      drive_op(F3_DIV,   32'hFFFFFFEC, 32'd3,        2'b00, 2'b00, 32'hFFFFFFFA, 0, 0);
      drive_op(F3_REM,   32'hFFFFFFEC, 32'd3,        2'b00, 2'b00, 32'hFFFFFFFE, 0, 0);
      drive_op(F3_DIVU,  32'd5,        32'd0,        2'b00, 2'b00, 32'hFFFFFFFF, 0, 0);
      drive_op(F3_REM,   32'd5,        32'd0,        2'b00, 2'b00, 32'd5,        0, 0);
      drive_op(F3_DIV,   32'h80000000, 32'hFFFFFFFF, 2'b00, 2'b00, 32'h80000000, 0, 0);
      drive_op(F3_DIV,   32'd100,      32'd7,        2'b00, 2'b00, 32'd14,      10, 1);
      drive_op(F3_REMU,  32'd12,       32'd5,        2'b01, 2'b00, 32'd2,        0, 0);
      drive_op(F3_DIVU,  32'd1000,     32'd3,        2'b00, 2'b00, 32'd333,      6, 2);
      drive_op(F3_MULHSU, 32'hFFFFFFFF, 32'h2,       2'b10, 2'b01, 32'hFFFFFFFF, 0, 0);

      for (int i = 0; i < 60; i++) begin
         f3 = 3'($urandom_range(0, 7));
         a  = pick();
         b  = pick();
         fa = 2'($urandom_range(0, 3));
         fb = 2'($urandom_range(0, 3));
         if (fa == fb && (fa == 2'b01 || fa == 2'b10)) b = a;
         ab_kind = 0;
         ab_cyc  = 0;
         if ($urandom_range(0, 7) == 0) begin
            ab_kind = 1;
            ab_cyc  = $urandom_range(1, latency(f3, a, b) - 1);
         end
         drive_op(f3, a, b, fa, fb, model(f3, a, b), ab_cyc, ab_kind);
      end

      @(posedge clk);
      #1;
      @(negedge clk);
      chk_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/ex_muldiv_unit.md
# ex_muldiv_unit

Execute-stage RV32M multiply/divide unit that consumes the forwarding-select codes driven into EX. It builds both operands through the same forwarding muxes the ALU uses: register file, MEM-stage result or WB-stage result. It runs MUL* ops in 2 cycles and DIV/REM ops with an iterative 1-bit-per-cycle divider, holding the pipeline through `stall` until the result is ready.

## Interface
- `XLEN`, 32: operand/result width; only 32 is supported.
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  synchronous, active-low reset
- `valid_ex`  in  1  EX holds a valid instruction
- `is_m_ex`  in  1  instruction is RV32M (opcode 0110011, funct7 0000001)
- `funct3_ex`  in  3  M-op select
- `rs1_data_ex`, `rs2_data_ex`  in  XLEN  register-file operands
- `alu_result_mem`  in  XLEN  MEM-stage forward source
- `wb_data`  in  XLEN  WB-stage forward source
- `forward_a`, `forward_b`  in  2  00 regfile, 01 WB, 10 MEM, 11 treated as 00
- `flush`  in  1  squash the in-flight op
- `stall`  out  1  freeze IF/ID/ID-EX; insert MEM bubble
- `result_valid`  out  1  `result` is valid this cycle
- `result`  out  XLEN  M-op result to EX/MEM

## Operation
- FSM states: IDLE, MUL, DIV, DONE.
- IDLE: `valid_ex & is_m_ex & !flush` accepts the op.
  - Latch the forwarded operands, funct3 and sign flags.
  - Go to MUL (funct3[2]=0) or DIV (funct3[2]=1).
  - Operands are captured only at accept; forward-source changes during the stall are ignored.
- MUL: compute a 33x33 signed product with sign-extension per op, register it, go to DONE.
  - MUL returns bits [31:0].
  - MULH, MULHSU and MULHU return bits [63:32], with signed×signed, signed×unsigned and unsigned×unsigned operands respectively.
- DIV: restoring divide on magnitudes, 5-bit counter 31 down to 0, then DONE; fix up signs at completion.
  - Special cases are detected at accept and go straight to DONE after one DIV cycle, with no iteration.
  - Divide by zero: quotient = all ones, remainder = dividend.
  - Signed overflow (0x80000000 / -1): quotient = 0x80000000, remainder = 0.
  - Remainder sign follows the dividend; quotient is negated when the signs differ (signed ops only).
- DONE: `result_valid`=1 for exactly one cycle, `stall`=0, next state IDLE.
  - No re-accept in DONE even though `valid_ex` is still high; the next instruction arrives in ID/EX the following cycle.
- `stall` = (IDLE & `valid_ex` & `is_m_ex` & !`flush`) | MUL | DIV. Combinational; forced 0 while `rst_n`=0.
- `flush` in any state → IDLE next cycle; no `result_valid`; counter cleared.
- Reset: state IDLE, `result`=0, `result_valid`=0, counter=0, latched operands=0.
- Non-M or invalid instructions: the unit stays IDLE, `stall`=0, `result` holds its last value.

## Timing
- Accept at cycle 0; `stall` is high in cycle 0.
- MUL ops: `result_valid` in cycle 2; `stall` high for cycles 0–1.
- DIV/REM: `result_valid` in cycle 33; `stall` high for cycles 0–32.
- Special-case divide: `result_valid` in cycle 2.
- `result` is registered and stable from DONE until the next op completes.
- `flush` takes priority over accept and completion in the same cycle.
- Reset mid-operation aborts on the next edge; no `result_valid`.

## Structure
- Shared `riscv_pkg` holds:
  - funct3 constants `F3_MUL` … `F3_REMU`;
  - forward codes `FWD_REG`, `FWD_WB`, `FWD_MEM`;
  - the state enum `md_state_t`.
- One sub-module `div_iter`: quotient/remainder shift registers and counter, with `start`/`busy`/`done`, on magnitudes only.
- Sign handling and the forwarding muxes stay in the top.

## Test plan
- MUL: rs1=7 (regfile), rs2 forwarded from MEM =−3 (`forward_b`=10) → `result`=0xFFFFFFEB in cycle 2; `stall` high for 2 cycles.
- MULHU: 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE. MULH: 0x80000000×0x80000000 → 0x40000000.
- DIV: −20/3 → 0xFFFFFFFA; REM: −20 % 3 → 0xFFFFFFFE. Each has `result_valid` in cycle 33, and `stall` is high for exactly 33 cycles.
- DIVU 5/0 → 0xFFFFFFFF; REM 5 % 0 → 5; DIV 0x80000000/−1 → 0x80000000. Each returns in cycle 2.
- `flush` in cycle 10 of a DIV → `stall` drops in cycle 11 and no `result_valid` is ever seen.
- WB forwarding: `forward_a`=01 with `wb_data`=12, then `wb_data` changed during the stall; REMU by 5 → `result`=2.
